// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the multi-lane MMIO UART write path.
// Holds the default data-port address and the serializer state codes.
package mmio_uart_tx_pkg;

  localparam logic [31:0] UART_ADDR_DEF = 32'hF6FF_F070;

  localparam logic [1:0] UART_IDLE  = 2'd0;
  localparam logic [1:0] UART_START = 2'd1;
  localparam logic [1:0] UART_DATA  = 2'd2;
  localparam logic [1:0] UART_STOP  = 2'd3;

  function automatic int cntW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Per-lane store bundle from the issue lanes into the UART block.
// The stall line flows back to hold the pipeline.
interface mmio_uart_tx_if #(
  parameter int LANES = 2
);

  logic [LANES-1:0]    st_en;
  logic [LANES*32-1:0] st_addr;
  logic [LANES*8-1:0]  st_data;
  logic                stall;

  modport master (
    output st_en, st_addr, st_data,
    input  stall
  );

  modport slave (
    input  st_en, st_addr, st_data,
    output stall
  );

endinterface

// File: rtl/mmio_uart_tx_serializer.sv
// 8N1 serializer: FSM, baud counter and shift register.
// Pops one byte from the FIFO head on each IDLE cycle with data waiting.
module uart_serializer_8n1
  import mmio_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       avail,
  input  logic [7:0] head,
  output logic       pop,
  output logic       busy,
  output logic       uartTx
);

  localparam int CW = cntW(CLKS_PER_BIT);

  logic [1:0]    state;
  logic [CW-1:0] baud;
  logic [2:0]    bitIdx;
  logic [7:0]    shReg;
  logic          txReg;
  logic          baudEnd;

  assign baudEnd = baud == CW'(CLKS_PER_BIT - 1);
  assign pop     = (state == UART_IDLE) && avail;
  assign busy    = state != UART_IDLE;
  assign uartTx  = txReg;

  // Line level is registered so the pin never glitches on state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= UART_IDLE;
      baud   <= '0;
      bitIdx <= '0;
      shReg  <= '0;
      txReg  <= 1'b1;
    end else begin
      unique case (state)
        UART_IDLE: begin
          baud <= '0;
          if (avail) begin
            shReg <= head;
            txReg <= 1'b0;
            state <= UART_START;
          end
        end
        UART_START: begin
          baud <= baudEnd ? '0 : baud + CW'(1);
          if (baudEnd) begin
            bitIdx <= '0;
            txReg  <= shReg[0];
            state  <= UART_DATA;
          end
        end
        UART_DATA: begin
          baud <= baudEnd ? '0 : baud + CW'(1);
          if (baudEnd) begin
            if (bitIdx == 3'd7) begin
              txReg <= 1'b1;
              state <= UART_STOP;
            end else begin
              bitIdx <= bitIdx + 3'd1;
              shReg  <= {1'b0, shReg[7:1]};
              txReg  <= shReg[1];
            end
          end
        end
        UART_STOP: begin
          baud <= baudEnd ? '0 : baud + CW'(1);
          if (baudEnd) state <= UART_IDLE;
        end
        default: state <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Multi-lane MMIO UART write path: lane decode, multi-write FIFO,
// all-or-nothing stall, and an 8N1 serializer on the FIFO head.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int          LANES        = 2,
  parameter int          DEPTH        = 16,
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] UART_ADDR    = UART_ADDR_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  mmio_uart_tx_if.slave              st,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       tx_busy,
  output logic                       uart_tx
);

  localparam int PW   = cntW(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [LANES-1:0] match;
  logic [PW-1:0]    off [LANES];
  logic [PW-1:0]    run;
  logic [CNTW:0]    nReq;
  logic [CNTW:0]    room;
  logic             accept;
  logic             pop;
  logic             serBusy;
  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;

  // Each matching lane lands at wrPtr plus the count of older matches.
  always_comb begin
    nReq = '0;
    run  = '0;
    for (int i = 0; i < LANES; i++) begin
      match[i] = st.st_en[i] &&
                 (st.st_addr[32*i +: 32] == UART_ADDR);
      off[i]   = run;
      run      = run + PW'(match[i]);
      nReq     = nReq + (CNTW+1)'(match[i]);
    end
  end

  assign room = (CNTW+1)'(DEPTH) - {1'b0, fifo_count}
              + (CNTW+1)'(pop);
  assign accept   = nReq <= room;
  assign st.stall = !accept;
  assign tx_busy  = serBusy || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (match[i]) mem[wrPtr + off[i]] <= st.st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
    end else begin
      if (accept) wrPtr <= wrPtr + PW'(nReq);
      if (pop) rdPtr <= rdPtr + PW'(1);
      fifo_count <= fifo_count
                  + (accept ? CNTW'(nReq) : '0)
                  - CNTW'(pop);
    end
  end

  uart_serializer_8n1 #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .avail  (fifo_count != '0),
    .head   (mem[rdPtr]),
    .pop    (pop),
    .busy   (serBusy),
    .uartTx (uart_tx)
  );

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: accepted bytes are queued,
// a line receiver decodes frames and compares against the queue.
module tb_mmio_uart_tx;

  localparam int          CPB = 4;
  localparam logic [31:0] UA  = 32'hF6FF_F070;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] fifo_count;
  logic       tx_busy;
  logic       uart_tx;

  mmio_uart_tx_if #(.LANES(2)) bus ();

  mmio_uart_tx #(
    .LANES        (2),
    .DEPTH        (4),
    .CLKS_PER_BIT (CPB),
    .UART_ADDR    (UA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .st         (bus),
    .fifo_count (fifo_count),
    .tx_busy    (tx_busy),
    .uart_tx    (uart_tx)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acceptCyc = 0;
  logic [7:0]  expQ [$];
  int          startQ [$];
  bit          rxActive = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int startAt(input int i);
    return (startQ.size() > i) ? startQ[i] : -100000;
  endfunction

  // Line receiver: samples mid-bit at the falling clock edge.
  initial begin
    int pos;
    logic [7:0] sh;
    pos = 0;
    sh = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rxActive = 1'b0;
      end else if (!rxActive) begin
        if (uart_tx === 1'b0) begin
          rxActive = 1'b1;
          pos = 0;
          startQ.push_back(cyc);
        end
      end else begin
        pos++;
        if (pos == 2) begin
          check("start_bit", {31'd0, uart_tx}, 1'b0);
        end else if (pos >= 6 && pos <= 34 && (pos % 4) == 2) begin
          sh[(pos - 6) / 4] = uart_tx;
        end else if (pos == 38) begin
          check("stop_bit", {31'd0, uart_tx}, 1'b1);
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame: got %02h want none", sh);
          end else begin
            check("frame", {24'd0, sh}, {24'd0, expQ.pop_front()});
          end
        end else if (pos == 39) begin
          rxActive = 1'b0;
        end
      end
    end
  end

  task automatic setLanes(input logic [1:0] en,
                          input logic [31:0] a0, a1,
                          input logic [7:0] d0, d1);
    bus.st_en   = en;
    bus.st_addr = {a1, a0};
    bus.st_data = {d1, d0};
  endtask

  task automatic store(input string name,
                       input logic [1:0] en,
                       input logic [31:0] a0, a1,
                       input logic [7:0] d0, d1,
                       input logic expStall);
    @(negedge clk);
    setLanes(en, a0, a1, d0, d1);
    #1;
    check({name, "_stall"}, {31'd0, bus.stall}, {31'd0, expStall});
    if (!expStall) begin
      if (en[0] && a0 == UA) expQ.push_back(d0);
      if (en[1] && a1 == UA) expQ.push_back(d1);
    end
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    bus.st_en = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((tx_busy || rxActive) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got busy want idle", name);
    end
    check({name, "_left"}, expQ.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic quiet;
    setLanes(2'b00, '0, '0, '0, '0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, uart_tx}, 1);
    check("rst_cnt", {29'd0, fifo_count}, 0);
    check("rst_busy", {31'd0, tx_busy}, 0);
    check("rst_stall", {31'd0, bus.stall}, 0);
    rst = 1'b0;

    // Single store of 'A' (0x41)
    startQ.delete();
    store("single", 2'b01, UA, '0, 8'h41, 8'h00, 1'b0);
    check("single_cnt1", {29'd0, fifo_count}, 1);
    @(posedge clk);
    #1;
    check("single_cnt0", {29'd0, fifo_count}, 0);
    repeat (39) @(posedge clk);
    #1;
    check("single_busy_end", {31'd0, tx_busy}, 1);
    @(posedge clk);
    #1;
    check("single_idle", {31'd0, tx_busy}, 0);
    drain("single");
    check("single_lat", startAt(0) - acceptCyc, 1);

    // Two lanes in one cycle
    startQ.delete();
    store("dual", 2'b11, UA, UA, 8'h31, 8'h32, 1'b0);
    check("dual_cnt2", {29'd0, fifo_count}, 2);
    @(posedge clk);
    #1;
    check("dual_cnt1", {29'd0, fifo_count}, 1);
    drain("dual");
    check("dual_gap", startAt(1) - startAt(0), 41);

    // Address filter and disabled lanes
    store("filt", 2'b10, UA, UA + 32'd4, 8'h66, 8'h77, 1'b0);
    check("filt_cnt", {29'd0, fifo_count}, 0);
    store("filt_hi", 2'b01, UA ^ 32'h8000_0000, '0,
          8'h55, 8'h00, 1'b0);
    check("filt_hi_cnt", {29'd0, fifo_count}, 0);
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      quiet = quiet & uart_tx;
    end
    check("filt_line", {31'd0, quiet}, 1);
    check("filt_busy", {31'd0, tx_busy}, 0);

    // Fill while busy, then backpressure
    store("bp0", 2'b01, UA, '0, 8'h50, 8'h00, 1'b0);
    repeat (10) @(posedge clk);
    store("bp1", 2'b11, UA, UA, 8'h51, 8'h52, 1'b0);
    store("bp2", 2'b11, UA, UA, 8'h53, 8'h54, 1'b0);
    check("bp_full", {29'd0, fifo_count}, 4);
    @(negedge clk);
    setLanes(2'b11, UA, UA, 8'h55, 8'h56);
    #1;
    check("bp_stall", {31'd0, bus.stall}, 1);
    check("bp_cnt_hold", {29'd0, fifo_count}, 4);
    w = 0;
    while (bus.stall === 1'b1 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("bp_released", {31'd0, bus.stall}, 0);
    check("bp_held", {31'd0, w > 40}, 1);
    check("bp_cnt_at_accept", {29'd0, fifo_count}, 3);
    expQ.push_back(8'h55);
    expQ.push_back(8'h56);
    @(posedge clk);
    #1;
    bus.st_en = '0;
    check("bp_cnt_after", {29'd0, fifo_count}, 4);

    // Push into a full FIFO on the popping IDLE cycle
    repeat (40) @(posedge clk);
    @(negedge clk);
    setLanes(2'b01, UA, '0, 8'h57, 8'h00);
    #1;
    check("pp_stall", {31'd0, bus.stall}, 0);
    check("pp_cnt_before", {29'd0, fifo_count}, 4);
    check("pp_idle_line", {31'd0, uart_tx}, 1);
    expQ.push_back(8'h57);
    @(posedge clk);
    #1;
    bus.st_en = '0;
    check("pp_cnt_after", {29'd0, fifo_count}, 4);
    check("pp_start", {31'd0, uart_tx}, 0);
    drain("bp");

    // Reset during DATA bit 3, then a clean frame
    store("rm", 2'b11, UA, UA, 8'h5A, 8'h5B, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    check("rm_pre_cnt", {29'd0, fifo_count}, 1);
    check("rm_pre_busy", {31'd0, tx_busy}, 1);
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    check("rm_tx", {31'd0, uart_tx}, 1);
    check("rm_cnt", {29'd0, fifo_count}, 0);
    check("rm_busy", {31'd0, tx_busy}, 0);
    check("rm_stall", {31'd0, bus.stall}, 0);
    rst = 1'b0;
    startQ.delete();
    store("post", 2'b01, UA, '0, 8'hC3, 8'h00, 1'b0);
    drain("post");
    check("post_lat", startAt(0) - acceptCyc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
